// File: rtl/vga_glyph_timing_pkg.sv
// Raster timing constants and shared widths
// for the glyph-mode VGA timing source.
package vga_timing_pkg;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_BOTTOM  = 10;
  localparam int V_SYNC    = 2;
  localparam int V_TOP     = 33;

  localparam int H_MAX =
    H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
  localparam int V_MAX =
    V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1;

  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 12;
  localparam int FRAME_W = 10;

  typedef logic [9:0] pos_t;
  typedef logic [6:0] col_t;
  typedef logic [5:0] row_t;
  typedef logic [3:0] gy_t;
  typedef logic [2:0] gx_t;

endpackage

// File: rtl/vga_glyph_timing_if.sv
// Timing bundle from the raster source
// to the glyph renderer.
interface vga_glyph_timing_if #(
  parameter int FRAME_W = 10
);
  import vga_timing_pkg::*;

  logic               hsync;
  logic               vsync;
  logic               display_on;
  pos_t               hpos;
  pos_t               vpos;
  col_t               col;
  gx_t                gx;
  row_t               row;
  gy_t                gy;
  logic [FRAME_W-1:0] frame;
  logic               frame_tick;
  logic               drop_done;

  modport master (
    output hsync, vsync, display_on,
    output hpos, vpos, col, gx, row, gy,
    output frame, frame_tick, drop_done
  );

  modport slave (
    input hsync, vsync, display_on,
    input hpos, vpos, col, gx, row, gy,
    input frame, frame_tick, drop_done
  );

endinterface

// File: rtl/vga_glyph_timing_cell.sv
// Modulo-N sub counter carrying into an index;
// used for glyph row / y-in-glyph tracking.
module glyph_cell_counter #(
  parameter int N  = 12,
  parameter int IW = 6,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          adv,
  input  logic          clr,
  output logic [IW-1:0] idx,
  output logic [SW-1:0] sub
);

  localparam logic [SW-1:0] LAST = SW'(N - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      sub <= '0;
    end else if (adv) begin
      if (clr) begin
        idx <= '0;
        sub <= '0;
      end else if (sub == LAST) begin
        idx <= idx + 1'b1;
        sub <= '0;
      end else begin
        sub <= sub + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_glyph_timing.sv
// 640x480@60 raster timing with incremental
// glyph-cell coordinates and frame counter.
module vga_glyph_timing #(
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_BOTTOM  = vga_timing_pkg::V_BOTTOM,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_TOP     = vga_timing_pkg::V_TOP,
  parameter int GLYPH_H   = vga_timing_pkg::GLYPH_H,
  parameter int FRAME_W   = vga_timing_pkg::FRAME_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze,
  vga_glyph_timing_if.master tim
);
  import vga_timing_pkg::*;

  localparam pos_t HMAX =
    pos_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam pos_t VMAX =
    pos_t'(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1);
  localparam pos_t HD  = pos_t'(H_DISPLAY);
  localparam pos_t VD  = pos_t'(V_DISPLAY);
  localparam pos_t HSS = pos_t'(H_DISPLAY + H_FRONT);
  localparam pos_t HSE = pos_t'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam pos_t VSS = pos_t'(V_DISPLAY + V_BOTTOM);
  localparam pos_t VSE = pos_t'(V_DISPLAY + V_BOTTOM + V_SYNC);

  pos_t               h;
  pos_t               v;
  pos_t               h_n;
  pos_t               v_n;
  logic               line_end;
  logic               hs;
  logic               vs;
  logic               de;
  logic               tick;
  logic               drop;
  logic [FRAME_W-1:0] frame;
  row_t               row;
  gy_t                gy;

  assign line_end = (h == HMAX);

  always_comb begin
    h_n = line_end ? '0 : h + 1'b1;
    v_n = v;
    if (line_end) v_n = (v == VMAX) ? '0 : v + 1'b1;
  end

  // Decode from the next position so every output lines up with h/v.
  always_ff @(posedge clk) begin
    if (reset) begin
      h    <= '0;
      v    <= '0;
      hs   <= 1'b1;
      vs   <= 1'b1;
      de   <= 1'b1;
      tick <= 1'b0;
    end else begin
      h    <= h_n;
      v    <= v_n;
      hs   <= !(h_n >= HSS && h_n < HSE);
      vs   <= !(v_n >= VSS && v_n < VSE);
      de   <= (h_n < HD) && (v_n < VD);
      tick <= (h_n == HMAX) && (v_n == VMAX);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame <= '0;
      drop  <= 1'b0;
    end else if (tick && !freeze) begin
      frame <= frame + 1'b1;
      if (&frame) drop <= 1'b1;
    end
  end

  glyph_cell_counter #(
    .N  (GLYPH_H),
    .IW (6),
    .SW (4)
  ) u_cell (
    .clk   (clk),
    .reset (reset),
    .adv   (line_end),
    .clr   (v == VMAX),
    .idx   (row),
    .sub   (gy)
  );

  assign tim.hpos       = h;
  assign tim.vpos       = v;
  assign tim.col        = h[9:3];
  assign tim.gx         = h[2:0];
  assign tim.row        = row;
  assign tim.gy         = gy;
  assign tim.hsync      = hs;
  assign tim.vsync      = vs;
  assign tim.display_on = de;
  assign tim.frame_tick = tick;
  assign tim.frame      = frame;
  assign tim.drop_done  = drop;

endmodule

// File: tb/tb_vga_glyph_timing.sv
// Bench for vga_glyph_timing: full 640x480 geometry
// plus a shrunk geometry to reach frame wraps quickly.
module tb_vga_glyph_timing;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic freeze = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_glyph_timing_if #(.FRAME_W(10)) full_if ();
  vga_glyph_timing_if #(.FRAME_W(3))  small_if ();

  vga_glyph_timing u_full (
    .clk    (clk),
    .reset  (reset),
    .freeze (freeze),
    .tim    (full_if)
  );

  // 24 px/line (sync 18..21), 37 lines (vsync 32..33), 3-bit frame
  vga_glyph_timing #(
    .H_DISPLAY (16), .H_FRONT (2), .H_SYNC (4), .H_BACK (2),
    .V_DISPLAY (30), .V_BOTTOM (2), .V_SYNC (2), .V_TOP (3),
    .GLYPH_H   (12), .FRAME_W (3)
  ) u_small (
    .clk    (clk),
    .reset  (reset),
    .freeze (freeze),
    .tim    (small_if)
  );

  wire [54:0] act_f = {
    full_if.hpos, full_if.vpos, full_if.col, full_if.gx,
    full_if.row, full_if.gy, full_if.hsync, full_if.vsync,
    full_if.display_on, full_if.frame_tick, full_if.frame,
    full_if.drop_done};
  wire [47:0] act_s = {
    small_if.hpos, small_if.vpos, small_if.col, small_if.gx,
    small_if.row, small_if.gy, small_if.hsync, small_if.vsync,
    small_if.display_on, small_if.frame_tick, small_if.frame,
    small_if.drop_done};

  localparam logic [54:0] RST_F = {40'd0, 4'b1110, 11'd0};
  localparam logic [47:0] RST_S = {40'd0, 4'b1110, 4'd0};

  // Reference: plain position counters, outputs derived arithmetically
  int fh = 0, fv = 0, ffr = 0, fdrop = 0;
  int sh = 0, sv = 0, sfr = 0, sdrop = 0;

  always @(posedge clk) begin
    if (reset) begin
      fh = 0; fv = 0; ffr = 0; fdrop = 0;
      sh = 0; sv = 0; sfr = 0; sdrop = 0;
    end else begin
      if (fh == 799 && fv == 524 && !freeze) begin
        if (ffr == 1023) fdrop = 1;
        ffr = (ffr + 1) % 1024;
      end
      if (sh == 23 && sv == 36 && !freeze) begin
        if (sfr == 7) sdrop = 1;
        sfr = (sfr + 1) % 8;
      end
      if (fh == 799) begin
        fh = 0;
        fv = (fv == 524) ? 0 : fv + 1;
      end else fh = fh + 1;
      if (sh == 23) begin
        sh = 0;
        sv = (sv == 36) ? 0 : sv + 1;
      end else sh = sh + 1;
    end
  end

  function automatic logic [54:0] exp_f();
    logic hs, vs, de, tk;
    hs = (fh >= 656 && fh < 752) ? 1'b0 : 1'b1;
    vs = (fv >= 490 && fv < 492) ? 1'b0 : 1'b1;
    de = (fh < 640 && fv < 480);
    tk = (fh == 799 && fv == 524);
    return {10'(fh), 10'(fv), 7'(fh / 8), 3'(fh % 8),
            6'(fv / 12), 4'(fv % 12), hs, vs, de, tk,
            10'(ffr), fdrop[0]};
  endfunction

  function automatic logic [47:0] exp_s();
    logic hs, vs, de, tk;
    hs = (sh >= 18 && sh < 22) ? 1'b0 : 1'b1;
    vs = (sv >= 32 && sv < 34) ? 1'b0 : 1'b1;
    de = (sh < 16 && sv < 30);
    tk = (sh == 23 && sv == 36);
    return {10'(sh), 10'(sv), 7'(sh / 8), 3'(sh % 8),
            6'(sv / 12), 4'(sv % 12), hs, vs, de, tk,
            3'(sfr), sdrop[0]};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (act_f !== RST_F) begin
      failures++;
      $display("FAIL reset_full got=%h exp=%h", act_f, RST_F);
    end
    checks++;
    if (act_s !== RST_S) begin
      failures++;
      $display("FAIL reset_small got=%h exp=%h", act_s, RST_S);
    end
    reset = 1'b0;
  endtask

  task automatic test_line();
    int hs_low = 0;
    int de_off = 0;
    bit wrapped = 0;
    int ph = 0;
    for (int i = 0; i < 1700; i++) begin
      @(negedge clk);
      checks++;
      if (act_f !== exp_f()) begin
        failures++;
        $display("FAIL line_vec t=%0d got=%h exp=%h",
                 i, act_f, exp_f());
      end
      if (full_if.vpos == 10'd0 && !full_if.hsync) hs_low++;
      if (full_if.vpos == 10'd0 && !full_if.display_on)
        de_off++;
      if (ph == 799 && full_if.hpos == 10'd0 &&
          full_if.vpos == 10'd1) wrapped = 1;
      ph = int'(full_if.hpos);
    end
    checks++;
    if (hs_low != 96) begin
      failures++;
      $display("FAIL hsync_width got=%0d exp=96", hs_low);
    end
    checks++;
    if (de_off != 160) begin
      failures++;
      $display("FAIL blank_width got=%0d exp=160", de_off);
    end
    checks++;
    if (!wrapped) begin
      failures++;
      $display("FAIL line_wrap got=0 exp=1");
    end
  endtask

  task automatic test_glyph();
    bit rolled = 0;
    int pgy = 0;
    int n = 0;
    while (fv < 26 && n < 30000) begin
      @(negedge clk);
      n++;
      checks++;
      if (act_f !== exp_f()) begin
        failures++;
        $display("FAIL glyph_vec got=%h exp=%h", act_f, exp_f());
      end
      checks++;
      if (int'(full_if.row) * 12 + int'(full_if.gy) !=
          int'(full_if.vpos)) begin
        failures++;
        $display("FAIL cell_inv row=%0d gy=%0d vpos=%0d",
                 full_if.row, full_if.gy, full_if.vpos);
      end
      if (pgy == 11 && full_if.gy == 4'd0 &&
          full_if.row == 6'd1) rolled = 1;
      pgy = int'(full_if.gy);
    end
    checks++;
    if (!rolled || n >= 30000) begin
      failures++;
      $display("FAIL gy_roll got=%0d exp=1 cycles=%0d", rolled, n);
    end
  endtask

  task automatic test_frame();
    int ticks = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 1826; i++) begin
      @(negedge clk);
      checks++;
      if (act_s !== exp_s()) begin
        failures++;
        $display("FAIL frame_vec t=%0d got=%h exp=%h",
                 i, act_s, exp_s());
      end
      if (small_if.frame_tick) ticks++;
      freeze = 1'($urandom % 2);
    end
    freeze = 1'b0;
    checks++;
    if (ticks != 2) begin
      failures++;
      $display("FAIL tick_count got=%0d exp=2", ticks);
    end
  endtask

  task automatic test_wrap();
    bit wrap_seen = 0;
    int pf = 0;
    freeze = 1'b0;
    pf = int'(small_if.frame);
    for (int i = 0; i < 9 * 888; i++) begin
      @(negedge clk);
      checks++;
      if (act_s !== exp_s()) begin
        failures++;
        $display("FAIL wrap_vec t=%0d got=%h exp=%h",
                 i, act_s, exp_s());
      end
      if (pf == 7 && small_if.frame == 3'd0 &&
          small_if.drop_done) wrap_seen = 1;
      pf = int'(small_if.frame);
    end
    checks++;
    if (!wrap_seen || small_if.drop_done !== 1'b1) begin
      failures++;
      $display("FAIL drop_set got=%0d/%0d exp=1/1",
               wrap_seen, small_if.drop_done);
    end
  endtask

  task automatic test_freeze();
    int ticks = 0;
    logic [2:0] f0;
    freeze = 1'b1;
    f0 = 3'(sfr);
    for (int i = 0; i < 3 * 888; i++) begin
      @(negedge clk);
      checks++;
      if (act_s !== exp_s()) begin
        failures++;
        $display("FAIL freeze_vec t=%0d got=%h exp=%h",
                 i, act_s, exp_s());
      end
      if (small_if.frame_tick) ticks++;
    end
    checks++;
    if (ticks != 3) begin
      failures++;
      $display("FAIL freeze_ticks got=%0d exp=3", ticks);
    end
    checks++;
    if (small_if.frame !== f0 || small_if.drop_done !== 1'b1) begin
      failures++;
      $display("FAIL freeze_hold got=%0d/%0d exp=%0d/1",
               small_if.frame, small_if.drop_done, f0);
    end
    freeze = 1'b0;
  endtask

  task automatic test_reset_on_tick();
    int n = 0;
    while (!(sh == 23 && sv == 36) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 1000 || small_if.frame_tick !== 1'b1) begin
      failures++;
      $display("FAIL tick_wait got=%0d exp=1 cycles=%0d",
               small_if.frame_tick, n);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (act_s !== RST_S) begin
      failures++;
      $display("FAIL tick_reset_small got=%h exp=%h", act_s, RST_S);
    end
    checks++;
    if (act_f !== RST_F) begin
      failures++;
      $display("FAIL midframe_reset got=%h exp=%h", act_f, RST_F);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (act_s !== exp_s() || small_if.hpos !== 10'd1) begin
      failures++;
      $display("FAIL post_reset got=%h exp=%h", act_s, exp_s());
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_glyph();
    test_frame();
    test_wrap();
    test_freeze();
    test_reset_on_tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_glyph_timing.md
Name: vga_glyph_timing

Overview:
- Single-clock raster timing source feeding the glyph-mode renderer.
- Produces 640x480@60 sync, pixel position and glyph-cell coordinates: column, row, x-in-glyph, y-in-glyph.
- Cell coordinates are counted incrementally, so the renderer needs no /12 divider or subtractors.
- Owns the animation frame counter and the sticky "first pass complete" flag; the renderer no longer clocks logic on vsync.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch
- V_DISPLAY, 480, visible lines
- V_BOTTOM, 10, vertical front porch
- V_SYNC, 2, vsync pulse lines
- V_TOP, 33, vertical back porch
- GLYPH_H, 12, glyph cell height in lines (cell width fixed at 8)
- FRAME_W, 10, frame counter width

Ports:
- clk, input, 1, pixel clock (25.175 MHz nominal)
- reset, input, 1, synchronous, active-high
- freeze, input, 1, holds frame counter (animation pause)
- hsync, output, 1, horizontal sync, active low
- vsync, output, 1, vertical sync, active low
- display_on, output, 1, high inside visible area
- hpos, output, 10, pixel column 0..799
- vpos, output, 10, line 0..524
- col, output, 7, hpos/8
- gx, output, 3, hpos mod 8
- row, output, 6, vpos/GLYPH_H (0..43)
- gy, output, 4, vpos mod GLYPH_H (0..11)
- frame, output, FRAME_W, frame counter
- frame_tick, output, 1, one-cycle pulse on last pixel of frame
- drop_done, output, 1, sticky: frame counter has wrapped at least once

Behaviour:
- All outputs are registered and mutually aligned: every output describes the same (hpos, vpos) in the same cycle.
- Reset, sampled on rising clk edge, gives next-cycle values:
  - hpos=0, vpos=0, row=0, gy=0, frame=0, drop_done=0, frame_tick=0
  - hsync=1, vsync=1, display_on=1
- Reset mid-frame behaves identically; no partial-line completion.
- H_MAX = sum of H params − 1 = 799; V_MAX = 524.
- hpos increments every cycle. At H_MAX it wraps to 0, and vpos advances (wraps to 0 at V_MAX).
- col and gx are bit-slices of hpos: col=hpos[9:3], gx=hpos[2:0].
- row/gy update only on the line-wrap cycle:
  - if vpos==V_MAX: row=0, gy=0
  - else if gy==GLYPH_H−1: gy=0, row=row+1
  - else gy=gy+1
- Invariant at every cycle: row*12+gy == vpos.
- hsync=0 iff H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC (656..751).
- vsync=0 iff V_DISPLAY+V_BOTTOM <= vpos < V_DISPLAY+V_BOTTOM+V_SYNC (490..491).
- display_on=1 iff hpos<640 and vpos<480.
- frame_tick=1 exactly in the cycle where hpos==H_MAX and vpos==V_MAX. This happens regardless of freeze.
- frame update on the edge ending the frame_tick cycle:
  - unless freeze=1, frame=frame+1, modulo 2^FRAME_W
  - if frame was all-ones and the increment occurs, drop_done sets
  - drop_done clears only on reset
- freeze changing mid-frame has no effect until the next tick.
- Simultaneous reset and tick: reset wins.

Decomposition:
- Package vga_timing_pkg holds:
  - the eight timing constants
  - derived H_MAX, V_MAX, H_SYNC_START/END, V_SYNC_START/END
  - GLYPH_W=8, GLYPH_H=12
  - typedefs for the pos (10-bit), col (7-bit), row (6-bit) widths
- One sub-module is natural: glyph_cell_counter, a generic "count modulo N with carry into index" counter. It is instantiated for row/gy, and is reusable for a future wider-cell mode.
- Sync/display decode stays inline.

Test Plan:
- Reset for 3 cycles, release → first cycle hpos=0, vpos=0, row=0, gy=0, display_on=1, hsync=vsync=1, frame=0.
- Run 800 cycles → hpos 799→0 and vpos 0→1. hsync low exactly for hpos 656..751 (96 cycles). display_on low for hpos 640..799.
- Run to vpos 11→12 → gy 11→0, row 0→1. Assert row*12+gy==vpos for every line of a full frame. At vpos 524→0, row 43→0 and gy 8→0.
- Full frame → vsync low only on vpos 490..491. frame_tick pulses once at (799,524). frame 0→1.
- Force 1024 frames (or preload frame=1023) → frame wraps to 0, drop_done=1. drop_done stays 1 through further frames and clears on reset.
- freeze=1 across 3 frames → frame constant, frame_tick still pulses 3 times. Assert reset on the tick cycle → frame=0, no increment.
